// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding selects, load-use stall,
// branch flush and data-memory wait freeze, with saturating statistics counters.
module pipe_hazard_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic [4:0]       RSAddr_ID,
    input  logic [4:0]       RTAddr_ID,
    input  logic             UsesRS_ID,
    input  logic             UsesRT_ID,
    input  logic [4:0]       RSAddr_EX,
    input  logic [4:0]       RTAddr_EX,
    input  logic             RegWriteEN_EX,
    input  logic             Mem2RegSEL_EX,
    input  logic [4:0]       DstAddr_EX,
    input  logic             BranchTaken_EX,
    input  logic             RegWriteEN_MEM,
    input  logic [4:0]       DstAddr_MEM,
    input  logic             RegWriteEN_WB,
    input  logic [4:0]       DstAddr_WB,
    input  logic             MemReq_MEM,
    input  logic             MemReady,
    output logic             PCWriteEN,
    output logic             IFIDWriteEN,
    output logic             IDEXWriteEN,
    output logic             EXMEMWriteEN,
    output logic             IFIDFlush,
    output logic             IDEXFlush,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic [1:0]       HazState,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StLuStall = 2'b01,
        StMemWait = 2'b10
    } haz_state_e;

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CntMax = '1;

    haz_state_e       state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             stall_inc, flush_inc;
    logic             mem_wait, branch, load_use;
    logic             rs_dep, rt_dep;

    // Hazard conditions, evaluated from current inputs and registered state.
    always_comb begin
        rs_dep   = UsesRS_ID && (RSAddr_ID == DstAddr_EX);
        rt_dep   = UsesRT_ID && (RTAddr_ID == DstAddr_EX);
        mem_wait = MemReq_MEM && !MemReady;
        branch   = BranchTaken_EX;
        // A load-use stall is only ever one cycle, so it is suppressed while stalling.
        load_use = (state_q != StLuStall) && RegWriteEN_EX && Mem2RegSEL_EX &&
                   (DstAddr_EX != 5'd0) && (rs_dep || rt_dep);
    end

    // Forwarding selects: MEM result wins over WB; $0 is never forwarded.
    always_comb begin
        ForwardA = 2'b00;
        ForwardB = 2'b00;
        if (RESET_N) begin
            if (RegWriteEN_MEM && (DstAddr_MEM != 5'd0) && (DstAddr_MEM == RSAddr_EX)) begin
                ForwardA = 2'b10;
            end else if (RegWriteEN_WB && (DstAddr_WB != 5'd0) &&
                         (DstAddr_WB == RSAddr_EX)) begin
                ForwardA = 2'b01;
            end
            if (RegWriteEN_MEM && (DstAddr_MEM != 5'd0) && (DstAddr_MEM == RTAddr_EX)) begin
                ForwardB = 2'b10;
            end else if (RegWriteEN_WB && (DstAddr_WB != 5'd0) &&
                         (DstAddr_WB == RTAddr_EX)) begin
                ForwardB = 2'b01;
            end
        end
    end

    // Next state and stage controls; priority is wait, then branch, then load-use.
    always_comb begin
        PCWriteEN    = 1'b1;
        IFIDWriteEN  = 1'b1;
        IDEXWriteEN  = 1'b1;
        EXMEMWriteEN = 1'b1;
        IFIDFlush    = 1'b0;
        IDEXFlush    = 1'b0;
        state_d      = StRun;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        if (!RESET_N) begin
            // Fill the pipeline registers with bubbles while held in reset.
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
        end else if (mem_wait) begin
            PCWriteEN    = 1'b0;
            IFIDWriteEN  = 1'b0;
            IDEXWriteEN  = 1'b0;
            EXMEMWriteEN = 1'b0;
            state_d      = StMemWait;
            stall_inc    = 1'b1;
        end else if (branch) begin
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
            flush_inc = 1'b1;
        end else if (load_use) begin
            PCWriteEN   = 1'b0;
            IFIDWriteEN = 1'b0;
            IDEXFlush   = 1'b1;
            state_d     = StLuStall;
            stall_inc   = 1'b1;
        end
    end

    // State register and saturating counters.
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            state_q     <= StRun;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (stall_inc && (stall_cnt_q != CntMax)) begin
                stall_cnt_q <= stall_cnt_q + CntOne;
            end
            if (flush_inc && (flush_cnt_q != CntMax)) begin
                flush_cnt_q <= flush_cnt_q + CntOne;
            end
        end
    end

    assign HazState   = state_q;
    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          CLOCK = 1'b0;
    logic          RESET_N;
    logic [4:0]    RSAddr_ID, RTAddr_ID, RSAddr_EX, RTAddr_EX;
    logic          UsesRS_ID, UsesRT_ID;
    logic          RegWriteEN_EX, Mem2RegSEL_EX, BranchTaken_EX;
    logic [4:0]    DstAddr_EX, DstAddr_MEM, DstAddr_WB;
    logic          RegWriteEN_MEM, RegWriteEN_WB, MemReq_MEM, MemReady;
    logic          PCWriteEN, IFIDWriteEN, IDEXWriteEN, EXMEMWriteEN;
    logic          IFIDFlush, IDEXFlush;
    logic [1:0]    ForwardA, ForwardB, HazState;
    logic [CW-1:0] StallCount, FlushCount;

    int n_cmp = 0;
    int n_bad = 0;
    bit run_cmp = 0;

    // Model state: HazState value (0 run, 1 load-use stall, 2 memory wait) and counts.
    int m_state = 0;
    int m_stall = 0;
    int m_flush = 0;

    typedef struct {
        bit pc, ifid, idex, exmem, fl_ifid, fl_idex;
        int fa, fb, nxt, add_stall, add_flush;
    } exp_t;

    pipe_hazard_ctrl #(.CNT_W(CW)) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N),
        .RSAddr_ID(RSAddr_ID), .RTAddr_ID(RTAddr_ID),
        .UsesRS_ID(UsesRS_ID), .UsesRT_ID(UsesRT_ID),
        .RSAddr_EX(RSAddr_EX), .RTAddr_EX(RTAddr_EX),
        .RegWriteEN_EX(RegWriteEN_EX), .Mem2RegSEL_EX(Mem2RegSEL_EX),
        .DstAddr_EX(DstAddr_EX), .BranchTaken_EX(BranchTaken_EX),
        .RegWriteEN_MEM(RegWriteEN_MEM), .DstAddr_MEM(DstAddr_MEM),
        .RegWriteEN_WB(RegWriteEN_WB), .DstAddr_WB(DstAddr_WB),
        .MemReq_MEM(MemReq_MEM), .MemReady(MemReady),
        .PCWriteEN(PCWriteEN), .IFIDWriteEN(IFIDWriteEN),
        .IDEXWriteEN(IDEXWriteEN), .EXMEMWriteEN(EXMEMWriteEN),
        .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush),
        .ForwardA(ForwardA), .ForwardB(ForwardB), .HazState(HazState),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    always #5 CLOCK = ~CLOCK;

    function automatic int fwd_sel(input int src);
        if (RegWriteEN_MEM && DstAddr_MEM != 0 && int'(DstAddr_MEM) == src) return 2;
        if (RegWriteEN_WB && DstAddr_WB != 0 && int'(DstAddr_WB) == src) return 1;
        return 0;
    endfunction

    // Outputs the rules demand for the current inputs and model state.
    function automatic exp_t model_eval();
        exp_t e;
        bit   hit;
        e = '{pc: 1, ifid: 1, idex: 1, exmem: 1, fl_ifid: 0, fl_idex: 0,
              fa: 0, fb: 0, nxt: 0, add_stall: 0, add_flush: 0};
        if (!RESET_N) begin
            e.fl_ifid = 1;
            e.fl_idex = 1;
            return e;
        end
        e.fa = fwd_sel(int'(RSAddr_EX));
        e.fb = fwd_sel(int'(RTAddr_EX));
        hit = (UsesRS_ID && RSAddr_ID == DstAddr_EX) || (UsesRT_ID && RTAddr_ID == DstAddr_EX);
        if (MemReq_MEM && !MemReady) begin
            {e.pc, e.ifid, e.idex, e.exmem} = 4'b0000;
            e.nxt = 2;
            e.add_stall = 1;
        end else if (BranchTaken_EX) begin
            {e.fl_ifid, e.fl_idex} = 2'b11;
            e.add_flush = 1;
        end else if (m_state != 1 && RegWriteEN_EX && Mem2RegSEL_EX && DstAddr_EX != 0 && hit) begin
            {e.pc, e.ifid, e.fl_idex} = 3'b001;
            e.nxt = 1;
            e.add_stall = 1;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model advance on the clock edge.
    always @(posedge CLOCK) begin
        exp_t e;
        e = model_eval();
        if (!RESET_N) begin
            m_state = 0;
            m_stall = 0;
            m_flush = 0;
        end else begin
            m_state = e.nxt;
            m_stall = (m_stall + e.add_stall > CMAX) ? CMAX : m_stall + e.add_stall;
            m_flush = (m_flush + e.add_flush > CMAX) ? CMAX : m_flush + e.add_flush;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge CLOCK) begin
        exp_t e;
        if (run_cmp) begin
            e = model_eval();
            check("m_PCWriteEN", 32'(PCWriteEN), 32'(e.pc));
            check("m_IFIDWriteEN", 32'(IFIDWriteEN), 32'(e.ifid));
            check("m_IDEXWriteEN", 32'(IDEXWriteEN), 32'(e.idex));
            check("m_EXMEMWriteEN", 32'(EXMEMWriteEN), 32'(e.exmem));
            check("m_IFIDFlush", 32'(IFIDFlush), 32'(e.fl_ifid));
            check("m_IDEXFlush", 32'(IDEXFlush), 32'(e.fl_idex));
            check("m_ForwardA", 32'(ForwardA), 32'(e.fa));
            check("m_ForwardB", 32'(ForwardB), 32'(e.fb));
            check("m_HazState", 32'(HazState), 32'(m_state));
            check("m_StallCount", 32'(StallCount), 32'(m_stall));
            check("m_FlushCount", 32'(FlushCount), 32'(m_flush));
        end
    end

    task automatic idle_inputs();
        {RSAddr_ID, RTAddr_ID, RSAddr_EX, RTAddr_EX} = '0;
        {UsesRS_ID, UsesRT_ID, RegWriteEN_EX, Mem2RegSEL_EX, BranchTaken_EX} = '0;
        {DstAddr_EX, DstAddr_MEM, DstAddr_WB} = '0;
        {RegWriteEN_MEM, RegWriteEN_WB, MemReq_MEM, MemReady} = '0;
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        RESET_N = 1'b0;
        tick();
        tick();
        RESET_N = 1'b1;
    endtask

    initial begin
        idle_inputs();
        RESET_N = 1'b0;
        tick();
        run_cmp = 1;
        tick();
        #2;
        check("rst_IFIDFlush", 32'(IFIDFlush), 1);
        check("rst_IDEXFlush", 32'(IDEXFlush), 1);
        check("rst_PCWriteEN", 32'(PCWriteEN), 1);
        check("rst_HazState", 32'(HazState), 0);
        check("rst_StallCount", 32'(StallCount), 0);
        RESET_N = 1'b1;
        tick();

        // Load-use: lw $5 in EX, ID reads rs=5.
        RegWriteEN_EX = 1; Mem2RegSEL_EX = 1; DstAddr_EX = 5;
        UsesRS_ID = 1; RSAddr_ID = 5;
        #2;
        check("lu_PCWriteEN", 32'(PCWriteEN), 0);
        check("lu_IFIDWriteEN", 32'(IFIDWriteEN), 0);
        check("lu_IDEXFlush", 32'(IDEXFlush), 1);
        tick();
        #2;
        check("lu_HazState", 32'(HazState), 1);
        check("lu_suppressed_PC", 32'(PCWriteEN), 1);
        tick();
        idle_inputs();
        #2;
        check("lu_HazState_after", 32'(HazState), 0);
        check("lu_StallCount", 32'(StallCount), 1);

        // Forwarding patterns.
        RSAddr_EX = 3; RTAddr_EX = 3;
        RegWriteEN_MEM = 1; DstAddr_MEM = 3; RegWriteEN_WB = 1; DstAddr_WB = 3;
        #2;
        check("fwd_memA", 32'(ForwardA), 2);
        check("fwd_memB", 32'(ForwardB), 2);
        DstAddr_MEM = 0;
        #2;
        check("fwd_wbA", 32'(ForwardA), 1);
        check("fwd_wbB", 32'(ForwardB), 1);
        DstAddr_WB = 0;
        #2;
        check("fwd_noneA", 32'(ForwardA), 0);
        RTAddr_EX = 7; DstAddr_WB = 7; DstAddr_MEM = 3;
        #2;
        check("fwd_splitA", 32'(ForwardA), 2);
        check("fwd_splitB", 32'(ForwardB), 1);
        tick();

        // Memory wait with a branch frozen in EX.
        do_reset();
        MemReq_MEM = 1; MemReady = 0; BranchTaken_EX = 1;
        for (int i = 0; i < 3; i++) begin
            #2;
            check("mw_PCWriteEN", 32'(PCWriteEN), 0);
            check("mw_EXMEMWriteEN", 32'(EXMEMWriteEN), 0);
            check("mw_IFIDFlush", 32'(IFIDFlush), 0);
            tick();
        end
        MemReady = 1;
        #2;
        check("mw_HazState", 32'(HazState), 2);
        check("mw_rel_IFIDFlush", 32'(IFIDFlush), 1);
        check("mw_rel_IDEXFlush", 32'(IDEXFlush), 1);
        tick();
        idle_inputs();
        #2;
        check("mw_StallCount", 32'(StallCount), 3);
        check("mw_FlushCount", 32'(FlushCount), 1);
        check("mw_HazState_after", 32'(HazState), 0);

        // Branch and load-use together: flush only.
        BranchTaken_EX = 1;
        RegWriteEN_EX = 1; Mem2RegSEL_EX = 1; DstAddr_EX = 9; UsesRT_ID = 1; RTAddr_ID = 9;
        #2;
        check("bl_PCWriteEN", 32'(PCWriteEN), 1);
        check("bl_IDEXFlush", 32'(IDEXFlush), 1);
        tick();
        idle_inputs();
        #2;
        check("bl_StallCount", 32'(StallCount), 3);
        check("bl_FlushCount", 32'(FlushCount), 2);
        check("bl_HazState", 32'(HazState), 0);

        // Saturation over 20 wait cycles.
        do_reset();
        MemReq_MEM = 1;
        repeat (20) tick();
        #2;
        check("sat_StallCount", 32'(StallCount), 15);

        // Reset during a wait.
        RESET_N = 0;
        #2;
        check("rw_IFIDFlush", 32'(IFIDFlush), 1);
        check("rw_IDEXFlush", 32'(IDEXFlush), 1);
        check("rw_IDEXWriteEN", 32'(IDEXWriteEN), 1);
        tick();
        RESET_N = 1;
        MemReq_MEM = 0;
        #2;
        check("rw_HazState", 32'(HazState), 0);
        check("rw_StallCount", 32'(StallCount), 0);
        check("rw_FlushCount", 32'(FlushCount), 0);
        tick();

        // Mixed vectors on small address ranges so hazards collide often.
        for (int i = 0; i < 400; i++) begin
            RESET_N        = ($urandom_range(0, 49) != 0);
            RSAddr_ID      = 5'($urandom_range(0, 3));
            RTAddr_ID      = 5'($urandom_range(0, 3));
            UsesRS_ID      = 1'($urandom);
            UsesRT_ID      = 1'($urandom);
            RSAddr_EX      = 5'($urandom_range(0, 3));
            RTAddr_EX      = 5'($urandom_range(0, 3));
            RegWriteEN_EX  = 1'($urandom);
            Mem2RegSEL_EX  = 1'($urandom);
            DstAddr_EX     = 5'($urandom_range(0, 3));
            BranchTaken_EX = ($urandom_range(0, 5) == 0);
            RegWriteEN_MEM = 1'($urandom);
            DstAddr_MEM    = 5'($urandom_range(0, 3));
            RegWriteEN_WB  = 1'($urandom);
            DstAddr_WB     = 5'($urandom_range(0, 3));
            MemReq_MEM     = ($urandom_range(0, 3) == 0);
            MemReady       = 1'($urandom);
            tick();
        end

        run_cmp = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
